// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition-to-DDR3 write path: FSM states,
// DDR3 user-interface command codes and address stepping.
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LATCH = 3'd2,
    ST_WR    = 3'd3,
    ST_DONE  = 3'd4
  } acq_state_t;

  localparam logic [2:0]  CMD_WRITE = 3'b000;
  localparam logic [2:0]  CMD_READ  = 3'b001;
  localparam logic [27:0] ADDR_STEP = 28'd8;

  // Word counter that sticks at its maximum instead of wrapping.
  function automatic logic [22:0] sat_inc(input logic [22:0] v);
    return (v == '1) ? v : v + 23'd1;
  endfunction

endpackage

// File: rtl/acq_ddr3_writer.sv
// Drains the acquisition FIFO one 128-bit word at a time into DDR3 through
// the user interface, tracking fill size and signalling fill completion.
module acq_ddr3_writer
  import acq_pkg::*;
(
  input  logic         clk200,
  input  logic         reset_clk200_n,
  input  logic [127:0] fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic         acq_done,
  input  logic         acq_reset,
  output logic         app_en,
  output logic [2:0]   app_cmd,
  output logic [27:0]  app_addr,
  input  logic         app_rdy,
  output logic [127:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  input  logic         app_wdf_rdy,
  output logic         ddr3_wr_done,
  output logic [22:0]  wr_word_count
);

  logic       rst_meta;
  logic       rst_sync_n;
  acq_state_t state;
  acq_state_t state_nxt;
  logic       cmd_acc;
  logic       dat_acc;
  logic       cmd_hs;
  logic       dat_hs;
  logic       both_done;

  // Assert immediately, release two clk200 edges after the pin goes high.
  always_ff @(posedge clk200 or negedge reset_clk200_n) begin
    if (!reset_clk200_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  assign app_cmd = CMD_WRITE;

  always_comb begin
    fifo_rd_en   = 1'b0;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    ddr3_wr_done = 1'b0;
    state_nxt    = state;

    // Strobes derive from state and accepted flags so each drops the cycle after its handshake.
    if (state == ST_RD)   fifo_rd_en   = !fifo_empty;
    if (state == ST_WR) begin
      app_en       = !cmd_acc;
      app_wdf_wren = !dat_acc;
    end
    if (state == ST_DONE) ddr3_wr_done = 1'b1;

    cmd_hs    = app_en & app_rdy;
    dat_hs    = app_wdf_wren & app_wdf_rdy;
    both_done = (cmd_acc | cmd_hs) & (dat_acc | dat_hs);

    case (state)
      ST_IDLE: begin
        if (!fifo_empty)
          state_nxt = ST_RD;
        else if (acq_done && (wr_word_count != '0))
          state_nxt = ST_DONE;
      end
      ST_RD:    state_nxt = fifo_empty ? ST_IDLE : ST_LATCH;
      ST_LATCH: state_nxt = ST_WR;
      ST_WR:    if (both_done) state_nxt = ST_IDLE;
      ST_DONE:  if (!acq_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    if (acq_reset) state_nxt = ST_IDLE;
  end

  assign app_wdf_end = app_wdf_wren;

  always_ff @(posedge clk200 or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state         <= ST_IDLE;
      cmd_acc       <= 1'b0;
      dat_acc       <= 1'b0;
      app_addr      <= '0;
      wr_word_count <= '0;
      app_wdf_data  <= '0;
    end else begin
      state <= state_nxt;
      if (acq_reset) begin
        cmd_acc       <= 1'b0;
        dat_acc       <= 1'b0;
        app_addr      <= '0;
        wr_word_count <= '0;
      end else begin
        case (state)
          ST_LATCH: begin
            app_wdf_data <= fifo_dout;
            cmd_acc      <= 1'b0;
            dat_acc      <= 1'b0;
          end
          ST_WR: begin
            if (both_done) begin
              wr_word_count <= sat_inc(wr_word_count);
              app_addr      <= app_addr + ADDR_STEP;
              cmd_acc       <= 1'b0;
              dat_acc       <= 1'b0;
            end else begin
              if (cmd_hs) cmd_acc <= 1'b1;
              if (dat_hs) dat_acc <= 1'b1;
            end
          end
          ST_DONE: begin
            if (!acq_done) begin
              wr_word_count <= '0;
              app_addr      <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_ddr3_writer.sv
// Randomized self-checking bench for acq_ddr3_writer with FIFO and DDR3 models.
module tb_acq_ddr3_writer;

  logic         clk200 = 1'b0;
  logic         reset_clk200_n;
  logic [127:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic         acq_done;
  logic         acq_reset;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic         ddr3_wr_done;
  logic [22:0]  wr_word_count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned rd_pulses = 0;
  int          cmd_stall = 0;
  int          dat_stall = 0;
  bit          rnd_rdy   = 1'b0;
  bit          cmd_hs_prev = 1'b0;
  bit          dat_hs_prev = 1'b0;

  logic [127:0] fq[$];
  logic [127:0] exp_data[$];
  logic [27:0]  obs_addr[$];
  logic [127:0] obs_data[$];

  acq_ddr3_writer dut (
    .clk200        (clk200),
    .reset_clk200_n(reset_clk200_n),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .acq_done      (acq_done),
    .acq_reset     (acq_reset),
    .app_en        (app_en),
    .app_cmd       (app_cmd),
    .app_addr      (app_addr),
    .app_rdy       (app_rdy),
    .app_wdf_data  (app_wdf_data),
    .app_wdf_wren  (app_wdf_wren),
    .app_wdf_end   (app_wdf_end),
    .app_wdf_rdy   (app_wdf_rdy),
    .ddr3_wr_done  (ddr3_wr_done),
    .wr_word_count (wr_word_count)
  );

  always #5 clk200 = ~clk200;

  // Standard-mode FIFO: data appears the edge after the read strobe.
  always @(posedge clk200) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_dout <= fq.pop_front();
      if (fq.size() == 0) fifo_empty <= 1'b1;
    end
  end

  // DDR3 ready driver: forced-low stalls first, then always-ready or random.
  always @(posedge clk200) begin
    #1;
    app_rdy     = (cmd_stall > 0) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    app_wdf_rdy = (dat_stall > 0) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Protocol monitor, sampled mid-cycle.
  always @(negedge clk200) begin
    if (reset_clk200_n) begin
      if (fifo_rd_en) begin
        rd_pulses++;
        total++;
        if (fifo_empty) begin bad++; $display("FAIL rd_en_while_empty got=1 want=0"); end
      end
      if (app_wdf_wren) begin
        total++;
        if (app_wdf_end !== 1'b1) begin bad++; $display("FAIL wdf_end got=%0b want=1", app_wdf_end); end
      end
      if (app_en) begin
        total++;
        if (app_cmd !== 3'b000) begin bad++; $display("FAIL app_cmd got=%0h want=0", app_cmd); end
      end
      if (cmd_hs_prev) begin
        total++;
        if (app_en !== 1'b0) begin bad++; $display("FAIL app_en_drop got=%0b want=0", app_en); end
      end
      if (dat_hs_prev) begin
        total++;
        if (app_wdf_wren !== 1'b0) begin bad++; $display("FAIL wren_drop got=%0b want=0", app_wdf_wren); end
      end
      cmd_hs_prev = app_en && app_rdy;
      dat_hs_prev = app_wdf_wren && app_wdf_rdy;
      if (cmd_hs_prev) obs_addr.push_back(app_addr);
      if (dat_hs_prev) obs_data.push_back(app_wdf_data);
      if (app_en && cmd_stall > 0) cmd_stall--;
      if (app_wdf_wren && dat_stall > 0) dat_stall--;
    end else begin
      cmd_hs_prev = 1'b0;
      dat_hs_prev = 1'b0;
    end
  end

  task automatic push_word(input logic [127:0] w);
    fq.push_back(w);
    exp_data.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_model();
    exp_data.delete();
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic wait_count(input int n, output bit ok);
    int c = 0;
    while (wr_word_count !== 23'(n) && c < 2000) begin @(negedge clk200); c++; end
    ok = (wr_word_count === 23'(n));
  endtask

  task automatic wait_done(output bit ok);
    int c = 0;
    while (ddr3_wr_done !== 1'b1 && c < 2000) begin @(negedge clk200); c++; end
    ok = (ddr3_wr_done === 1'b1);
  endtask

  task automatic pulse_acq_reset();
    @(posedge clk200); #1 acq_reset = 1'b1;
    @(posedge clk200); #1 acq_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_clk200_n = 1'b0;
    #1;
    total++;
    if ({app_en, app_wdf_wren, app_wdf_end, fifo_rd_en, ddr3_wr_done} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=00000",
                      {app_en, app_wdf_wren, app_wdf_end, fifo_rd_en, ddr3_wr_done});
    end
    repeat (3) @(posedge clk200);
    #1;
    total++;
    if (app_addr !== 28'd0 || wr_word_count !== 23'd0 || app_wdf_data !== 128'd0 || app_cmd !== 3'd0) begin
      bad++; $display("FAIL reset_regs addr=%0h cnt=%0d data=%0h cmd=%0h want all 0",
                      app_addr, wr_word_count, app_wdf_data, app_cmd);
    end
    reset_clk200_n = 1'b1;
    repeat (4) @(posedge clk200);
    #1;
    total++;
    if ({app_en, app_wdf_wren, fifo_rd_en, ddr3_wr_done} !== 4'b0 || wr_word_count !== 23'd0) begin
      bad++; $display("FAIL idle_after_reset strobes=%b cnt=%0d want 0",
                      {app_en, app_wdf_wren, fifo_rd_en, ddr3_wr_done}, wr_word_count);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_model();
    @(posedge clk200); #1;
    push_word(128'h0055_0008_0123_4567_89AB_CDEF_0000_0001);
    acq_done = 1'b1;
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_done_timeout got=%0b want=1", ddr3_wr_done); end
    total++;
    if (obs_addr.size() != 1 || obs_data.size() != 1) begin
      bad++; $display("FAIL single_nwrites cmd=%0d data=%0d want=1", obs_addr.size(), obs_data.size());
    end else begin
      total++;
      if (obs_addr[0] !== 28'd0) begin bad++; $display("FAIL single_addr got=%0h want=0", obs_addr[0]); end
      total++;
      if (obs_data[0] !== exp_data[0]) begin bad++; $display("FAIL single_data got=%0h want=%0h", obs_data[0], exp_data[0]); end
    end
    total++;
    if (wr_word_count !== 23'd1) begin bad++; $display("FAIL single_count got=%0d want=1", wr_word_count); end
    @(posedge clk200); #1 acq_done = 1'b0;
    repeat (2) @(negedge clk200);
    total++;
    if (ddr3_wr_done !== 1'b0 || wr_word_count !== 23'd0 || app_addr !== 28'd0) begin
      bad++; $display("FAIL done_clear done=%0b cnt=%0d addr=%0h want 0", ddr3_wr_done, wr_word_count, app_addr);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    clear_model();
    @(posedge clk200); #1;
    cmd_stall = 3;
    dat_stall = 5;
    for (int i = 0; i < 4; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    acq_done = 1'b1;
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_done_timeout got=%0b want=1", ddr3_wr_done); end
    total++;
    if (obs_addr.size() != 4 || obs_data.size() != 4) begin
      bad++; $display("FAIL bp_nwrites cmd=%0d data=%0d want=4", obs_addr.size(), obs_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_addr[i] !== 28'(i * 8)) begin bad++; $display("FAIL bp_addr[%0d] got=%0h want=%0h", i, obs_addr[i], i * 8); end
        total++;
        if (obs_data[i] !== exp_data[i]) begin bad++; $display("FAIL bp_data[%0d] got=%0h want=%0h", i, obs_data[i], exp_data[i]); end
      end
    end
    total++;
    if (wr_word_count !== 23'd4) begin bad++; $display("FAIL bp_count got=%0d want=4", wr_word_count); end
    @(posedge clk200); #1 acq_done = 1'b0;
    repeat (2) @(negedge clk200);
  endtask

  task automatic test_late_done();
    bit ok;
    int unsigned rd0;
    clear_model();
    rd0 = rd_pulses;
    @(posedge clk200); #1;
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    wait_count(3, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL late_count_timeout got=%0d want=3", wr_word_count); end
    repeat (20) @(negedge clk200);
    total++;
    if (ddr3_wr_done !== 1'b0) begin bad++; $display("FAIL late_early_done got=%0b want=0", ddr3_wr_done); end
    @(posedge clk200); #1 acq_done = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk200);
      if (ddr3_wr_done === 1'b1) ok = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL late_done_latency got=%0b want=1 within 2 cycles", ddr3_wr_done); end
    total++;
    if (rd_pulses - rd0 != 3) begin bad++; $display("FAIL late_rd_pulses got=%0d want=3", rd_pulses - rd0); end
    total++;
    if (obs_data.size() != 3 || obs_data[2] !== exp_data[2] || obs_addr[2] !== 28'd16) begin
      bad++; $display("FAIL late_writes n=%0d want=3 with last at addr 10", obs_data.size());
    end
    @(posedge clk200); #1 acq_done = 1'b0;
    repeat (2) @(negedge clk200);
  endtask

  task automatic test_random();
    bit ok;
    int n;
    rnd_rdy = 1'b1;
    for (int r = 0; r < 3; r++) begin
      clear_model();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        @(posedge clk200); #1;
        push_word({$urandom, $urandom, $urandom, $urandom});
        repeat ($urandom_range(0, 6)) @(posedge clk200);
        #1;
      end
      acq_done = 1'b1;
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rnd%0d_done_timeout got=%0b want=1", r, ddr3_wr_done); end
      total++;
      if (obs_addr.size() != n || obs_data.size() != n) begin
        bad++; $display("FAIL rnd%0d_nwrites cmd=%0d data=%0d want=%0d", r, obs_addr.size(), obs_data.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          total++;
          if (obs_addr[i] !== 28'(i * 8) || obs_data[i] !== exp_data[i]) begin
            bad++; $display("FAIL rnd%0d_write[%0d] addr=%0h data=%0h want addr=%0h data=%0h",
                            r, i, obs_addr[i], obs_data[i], i * 8, exp_data[i]);
          end
        end
      end
      total++;
      if (wr_word_count !== 23'(n)) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", r, wr_word_count, n); end
      @(posedge clk200); #1 acq_done = 1'b0;
      repeat (2) @(negedge clk200);
    end
    rnd_rdy = 1'b0;
  endtask

  task automatic test_abort();
    bit ok;
    int c;
    clear_model();
    @(posedge clk200); #1;
    push_word(128'hA);
    push_word(128'hB);
    wait_count(2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL abort_pre_count got=%0d want=2", wr_word_count); end
    cmd_stall = 1000;
    @(posedge clk200); #1;
    push_word(128'hC);
    c = 0;
    while (app_en !== 1'b1 && c < 200) begin @(negedge clk200); c++; end
    total++;
    if (app_en !== 1'b1) begin bad++; $display("FAIL abort_wr_timeout got=%0b want=1", app_en); end
    pulse_acq_reset();
    total++;
    if ({app_en, app_wdf_wren, fifo_rd_en, ddr3_wr_done} !== 4'b0 || wr_word_count !== 23'd0 || app_addr !== 28'd0) begin
      bad++; $display("FAIL abort_clear strobes=%b cnt=%0d addr=%0h want 0",
                      {app_en, app_wdf_wren, fifo_rd_en, ddr3_wr_done}, wr_word_count, app_addr);
    end
    cmd_stall = 0;
    repeat (3) @(negedge clk200);
    total++;
    if (app_en !== 1'b0 || fifo_rd_en !== 1'b0) begin
      bad++; $display("FAIL abort_idle en=%0b rd=%0b want 0", app_en, fifo_rd_en);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_model();
    @(negedge clk200);
    force dut.app_addr = 28'hFFFFFF8;
    @(posedge clk200); #1;
    release dut.app_addr;
    push_word({$urandom, $urandom, $urandom, $urandom});
    push_word({$urandom, $urandom, $urandom, $urandom});
    wait_count(2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_timeout got=%0d want=2", wr_word_count); end
    total++;
    if (obs_addr.size() != 2 || obs_addr[0] !== 28'hFFFFFF8 || obs_addr[1] !== 28'h0) begin
      bad++; $display("FAIL wrap_addrs n=%0d first=%0h second=%0h want FFFFFF8,0",
                      obs_addr.size(), obs_addr[0], obs_addr[1]);
    end
    total++;
    if (app_addr !== 28'h8) begin bad++; $display("FAIL wrap_next_addr got=%0h want=8", app_addr); end
    pulse_acq_reset();
  endtask

  task automatic test_async_reset();
    bit ok;
    int c;
    clear_model();
    cmd_stall = 1000;
    @(posedge clk200); #1;
    push_word(128'h1111);
    c = 0;
    while (app_en !== 1'b1 && c < 200) begin @(negedge clk200); c++; end
    total++;
    if (app_en !== 1'b1) begin bad++; $display("FAIL areset_wr_timeout got=%0b want=1", app_en); end
    @(posedge clk200); #3 reset_clk200_n = 1'b0;
    #1;
    total++;
    if ({app_en, app_wdf_wren, app_wdf_end, fifo_rd_en, ddr3_wr_done} !== 5'b0 ||
        app_addr !== 28'd0 || wr_word_count !== 23'd0 || app_wdf_data !== 128'd0) begin
      bad++; $display("FAIL areset_immediate strobes=%b addr=%0h cnt=%0d data=%0h want 0",
                      {app_en, app_wdf_wren, app_wdf_end, fifo_rd_en, ddr3_wr_done},
                      app_addr, wr_word_count, app_wdf_data);
    end
    cmd_stall = 0;
    clear_model();
    repeat (2) @(posedge clk200);
    #3 reset_clk200_n = 1'b1;
    push_word(128'h2222);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk200);
      @(negedge clk200);
      total++;
      if (fifo_rd_en !== (k == 3)) begin
        bad++; $display("FAIL areset_release_edge%0d rd_en got=%0b want=%0b", k, fifo_rd_en, (k == 3));
      end
    end
    wait_count(1, ok);
    total++;
    if (!ok || obs_addr.size() != 1 || obs_addr[0] !== 28'd0 || obs_data[0] !== 128'h2222) begin
      bad++; $display("FAIL areset_resume cnt=%0d n=%0d want one write of 2222 at 0",
                      wr_word_count, obs_addr.size());
    end
    pulse_acq_reset();
  endtask

  initial begin
    fifo_empty  = 1'b1;
    fifo_dout   = '0;
    acq_done    = 1'b0;
    acq_reset   = 1'b0;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    test_reset();
    test_single();
    test_back_pressure();
    test_late_done();
    test_random();
    test_abort();
    test_wrap();
    test_async_reset();
    repeat (3) @(posedge clk200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acq_ddr3_writer.md
ACQ_DDR3_WRITER -- requirements
Module: acq_ddr3_writer

Interface
REQ-001 SHALL have port clk200, input, 1: single clock for all logic; FIFO read side and DDR3 user interface run on it.
REQ-002 SHALL have port reset_clk200_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port fifo_dout, input, 128: header or ADC word from the acquisition FIFO, valid 1 cycle after fifo_rd_en (standard read mode).
REQ-004 SHALL have port fifo_empty, input, 1: acquisition FIFO empty.
REQ-005 SHALL have port fifo_rd_en, output, 1: FIFO read strobe, one word per asserted cycle.
REQ-006 SHALL have port acq_done, input, 1: level, acquisition has pushed its last word for this fill.
REQ-007 SHALL have port acq_reset, input, 1: synchronous abort of the current fill.
REQ-008 SHALL have ports app_en (output, 1), app_cmd (output, 3, write = 3'b000), app_addr (output, 28) and app_rdy (input, 1): DDR3 command channel.
REQ-009 SHALL have ports app_wdf_data (output, 128), app_wdf_wren (output, 1), app_wdf_end (output, 1) and app_wdf_rdy (input, 1): DDR3 write-data channel.
REQ-010 SHALL have port ddr3_wr_done, output, 1: fill fully written to DDR3.
REQ-011 SHALL have port wr_word_count, output, 23: 128-bit words written in the current fill.

Function
REQ-012 SHALL implement states IDLE, RD, LATCH, WR, DONE.
REQ-013 IDLE SHALL move to RD when fifo_empty = 0; it SHALL move to DONE when fifo_empty = 1 and acq_done = 1 and wr_word_count > 0.
REQ-014 RD SHALL assert fifo_rd_en for exactly one cycle, then move to LATCH.
REQ-015 LATCH SHALL register fifo_dout into app_wdf_data, clear both accepted flags and move to WR.
REQ-016 WR SHALL hold app_en and app_wdf_wren high with app_wdf_end = app_wdf_wren, app_cmd = write and app_addr stable, until each channel completes its own handshake.
REQ-017 The command handshake completes when app_en = 1 and app_rdy = 1; the data handshake completes when app_wdf_wren = 1 and app_wdf_rdy = 1. The two may complete in the same cycle or in either order; each strobe SHALL drop the cycle after its own handshake.
REQ-018 When both handshakes have completed, the block SHALL increment wr_word_count, add 8 to app_addr and return to IDLE.
REQ-019 app_addr SHALL wrap modulo 2^28 without any error indication; wr_word_count SHALL saturate at 23'h7FFFFF.
REQ-020 DONE SHALL hold ddr3_wr_done = 1 while acq_done = 1. When acq_done falls, the block SHALL clear ddr3_wr_done, wr_word_count and app_addr, then go to IDLE.
REQ-021 If acq_done = 1 while the FIFO is non-empty, the block SHALL drain the FIFO before entering DONE.
REQ-022 fifo_rd_en SHALL never be asserted while fifo_empty = 1, nor outside the RD state.
REQ-023 acq_reset = 1 SHALL force IDLE and clear app_en, app_wdf_wren, fifo_rd_en, ddr3_wr_done, wr_word_count and app_addr on the next edge, from any state, including mid-handshake. acq_reset has priority over all other events.

Reset
REQ-024 While reset_clk200_n = 0, the block SHALL be in IDLE with every output at 0 (app_cmd = 3'b000, app_wdf_data = 0).
REQ-025 Reset SHALL assert asynchronously. Release SHALL pass through a 2-flop synchronizer inside the block, so that deassertion is synchronous to clk200.

Structure
REQ-026 The state encoding, DDR3 command codes (CMD_WRITE, CMD_READ) and the address step (ADDR_STEP = 8) SHALL live in the shared package acq_pkg.
REQ-027 The block SHALL be a single module with no sub-modules; the synchronizer SHALL be inline.

Verification
REQ-028 Single word: FIFO holds 1 word, 128'h0055_0008_..., acq_done = 1, app_rdy = app_wdf_rdy = 1 -> one write to addr 0, wr_word_count = 1, ddr3_wr_done = 1.
REQ-029 Back-pressure: 4 words, with app_rdy low 3 cycles and app_wdf_rdy low 5 cycles (independently) -> 4 writes to addrs 0, 8, 16, 24; each strobe drops after its own handshake; data order preserved.
REQ-030 Late done: 3 words, then acq_done rises 20 cycles after the FIFO empties -> ddr3_wr_done rises within 2 cycles of acq_done; no extra fifo_rd_en.
REQ-031 Abort: acq_reset pulsed in WR with app_rdy = 0 -> next cycle all strobes = 0, counters = 0, state IDLE.
REQ-032 Wrap: app_addr preset to 28'hFFFFFF8 via 2^25-1 writes (forced) -> next write to 28'hFFFFFF8, following write to 0.
REQ-033 Async reset: reset_clk200_n pulled low mid-clock during WR -> outputs 0 immediately; writing resumes only 2 cycles after release.
